// File: rtl/barcode_tx_if.sv
// Request/status bundle between a station controller and barcode_tx.
//   send       : one-cycle transmit request
//   station_ID : 8-bit ID, sampled on an accepted send
//   period     : requested cell length in clk cycles, sampled on an accepted send
//   BC         : serial barcode line, idles high
//   busy       : frame in progress
//   done       : one-cycle end-of-frame pulse
interface barcode_tx_if #(
    parameter int unsigned PW = 22
) ();
    logic          send;
    logic [7:0]    station_ID;
    logic [PW-1:0] period;
    logic          BC;
    logic          busy;
    logic          done;

    // Controller side.
    modport master (
        output send, station_ID, period,
        input  BC, busy, done
    );

    // Transmitter side.
    modport slave (
        input  send, station_ID, period,
        output BC, busy, done
    );
endinterface

// File: rtl/barcode_tx.sv
// Serial barcode transmitter. Sends a start cell followed by 8 data cells
// (MSB first) on BC; each cell is P clocks long and starts with BC low.
// The low time is 3P/4 for the start cell and for a zero, and P/4 for a one.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : barcode_tx_if slave (send/station_ID/period in, BC/busy/done out)
module barcode_tx #(
    parameter int unsigned PW         = 22,
    parameter int unsigned MIN_PERIOD = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    barcode_tx_if.slave   bus
);

    localparam int unsigned CW        = 4;
    localparam logic [CW-1:0] LAST_CELL = CW'(8);
    localparam logic [PW-1:0] MIN_P     = PW'(MIN_PERIOD);

    typedef enum logic {
        IDLE,
        CELL
    } state_e;

    state_e        state_q, state_d;
    logic [CW-1:0] cell_q, cell_d;
    logic [PW-1:0] timer_q, timer_d;
    logic [7:0]    shift_q, shift_d;
    logic [PW-1:0] per_q, per_d;
    logic          bc_q, bc_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic [PW-1:0] low_d;

    // Next-state and registered-output logic.
    always_comb begin
        state_d = state_q;
        cell_d  = cell_q;
        timer_d = timer_q;
        shift_d = shift_q;
        per_d   = per_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        low_d   = '0;
        bc_d    = 1'b1;

        case (state_q)
            IDLE: begin
                if (bus.send) begin
                    state_d = CELL;
                    shift_d = bus.station_ID;
                    per_d   = (bus.period < MIN_P) ? MIN_P : bus.period;
                    cell_d  = '0;
                    timer_d = '0;
                    busy_d  = 1'b1;
                end
            end
            CELL: begin
                if (timer_q == per_q - PW'(1)) begin
                    if (cell_q == LAST_CELL) begin
                        state_d = IDLE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        cell_d  = cell_q + CW'(1);
                        timer_d = '0;
                        // The start cell carries no data, so the MSB stays
                        // in place until data cell 1 has been sent.
                        if (cell_q != '0) begin
                            shift_d = {shift_q[6:0], 1'b0};
                        end
                    end
                end else begin
                    timer_d = timer_q + PW'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // BC for the coming cycle is derived from the coming timer/cell so
        // the line itself comes straight from a flop.
        if ((cell_d != '0) && shift_d[7]) begin
            low_d = per_d >> 2;
        end else begin
            low_d = per_d - (per_d >> 2);
        end
        if (state_d == CELL) begin
            bc_d = (timer_d >= low_d);
        end
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cell_q  <= '0;
            timer_q <= '0;
            shift_q <= '0;
            per_q   <= MIN_P;
            bc_q    <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cell_q  <= cell_d;
            timer_q <= timer_d;
            shift_q <= shift_d;
            per_q   <= per_d;
            bc_q    <= bc_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign bus.BC   = bc_q;
    assign bus.busy = busy_q;
    assign bus.done = done_q;

endmodule

// File: tb/tb_barcode_tx.sv
// Testbench for barcode_tx: drives frames with random IDs/periods and checks
// the BC waveform, busy and done against a cell-arithmetic model, and decodes
// the ID the way the downstream reader does.
module tb_barcode_tx;

    localparam int unsigned PW   = 22;
    localparam int unsigned MINP = 16;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    barcode_tx_if #(.PW(PW)) bus ();

    barcode_tx #(.PW(PW), .MIN_PERIOD(MINP)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    function automatic int eff_period(input int unsigned p);
        return (p < MINP) ? int'(MINP) : int'(p);
    endfunction

    // Expected BC at offset t after the first falling edge of a frame.
    function automatic logic model_bc(input logic [7:0] id, input int p, input int t);
        int c;
        int tt;
        int lo;
        if (t >= 9 * p) return 1'b1;
        c  = t / p;
        tt = t % p;
        if (c == 0)          lo = p - p / 4;
        else if (id[8 - c])  lo = p / 4;
        else                 lo = p - p / 4;
        return (tt >= lo);
    endfunction

    // Issue one accepted send; returns at the first cycle of the frame.
    task automatic start_frame(input logic [7:0] id, input int unsigned per);
        bus.send       = 1'b1;
        bus.station_ID = id;
        bus.period     = PW'(per);
        @(negedge clk);
        bus.send       = 1'b0;
        bus.station_ID = 8'($urandom);
        bus.period     = PW'($urandom_range(0, 4000));
    endtask

    // Follow one frame from its first cycle through the done cycle.
    task automatic run_frame(input string name, input logic [7:0] id, input int unsigned per,
                             input bit inject, input bit chain,
                             input logic [7:0] nid, input int unsigned nper);
        int   p;
        int   total;
        logic tr[$];
        int   falls[$];
        int   bc_bad, busy_bad, done_bad, first_bad;
        logic got_first;
        bit   spacing_ok;
        logic [7:0] dec;

        p = eff_period(per);
        total = 9 * p;
        bc_bad = 0; busy_bad = 0; done_bad = 0; first_bad = -1; got_first = 1'b0;

        for (int t = 0; t <= total; t++) begin
            logic exp_bc;
            exp_bc = model_bc(id, p, t);
            tr.push_back(bus.BC);
            if (bus.BC !== exp_bc) begin
                bc_bad++;
                if (first_bad < 0) begin
                    first_bad = t;
                    got_first = bus.BC;
                end
            end
            if (bus.busy !== (t < total)) busy_bad++;
            if (bus.done !== (t == total)) done_bad++;
            // Inputs wander mid-frame; stray sends must be ignored.
            bus.station_ID = 8'($urandom);
            bus.period     = PW'($urandom_range(0, 4000));
            bus.send       = (inject && (t == 10 || t == 500)) || (chain && t == total);
            if (chain && t == total) begin
                bus.station_ID = nid;
                bus.period     = PW'(nper);
            end
            @(negedge clk);
        end
        bus.send = 1'b0;

        n_vec++;
        if (bc_bad != 0) begin
            n_err++;
            $display("FAIL %s waveform: %0d BC cycles wrong, first at offset %0d got %b want %b",
                     name, bc_bad, first_bad, got_first, model_bc(id, p, first_bad));
        end
        n_vec++;
        if (busy_bad != 0) begin
            n_err++;
            $display("FAIL %s busy: %0d cycles wrong, want busy for exactly %0d cycles",
                     name, busy_bad, total);
        end
        n_vec++;
        if (done_bad != 0) begin
            n_err++;
            $display("FAIL %s done: %0d cycles wrong, want single pulse at offset %0d",
                     name, done_bad, total);
        end

        // Reader view: falling edges and mid-cell samples.
        for (int i = 0; i < tr.size(); i++) begin
            if (tr[i] === 1'b0 && (i == 0 || tr[i-1] === 1'b1)) falls.push_back(i);
        end
        n_vec++;
        if (falls.size() != 9) begin
            n_err++;
            $display("FAIL %s falls: got %0d falling edges want 9", name, falls.size());
        end
        spacing_ok = 1'b1;
        for (int k = 0; k < falls.size(); k++) begin
            if (falls[k] != k * p) spacing_ok = 1'b0;
        end
        n_vec++;
        if (!spacing_ok) begin
            n_err++;
            $display("FAIL %s spacing: falling edges not every %0d cycles", name, p);
        end
        dec = '0;
        for (int k = 1; k <= 8; k++) begin
            logic b;
            b = 1'bx;
            if (k < falls.size() && falls[k] + p / 2 < tr.size()) b = tr[falls[k] + p / 2];
            dec = {dec[6:0], b};
        end
        n_vec++;
        if (dec !== id) begin
            n_err++;
            $display("FAIL %s decode: got ID %h want %h", name, dec, id);
        end

        if (!chain) begin
            n_vec++;
            if ({bus.BC, bus.busy, bus.done} !== 3'b100) begin
                n_err++;
                $display("FAIL %s idle after done: got BC/busy/done %b want 100",
                         name, {bus.BC, bus.busy, bus.done});
            end
        end
    endtask

    task automatic test_reset();
        bus.send = 1'b0;
        bus.station_ID = 8'h00;
        bus.period = '0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        n_vec++;
        if ({bus.BC, bus.busy, bus.done} !== 3'b100) begin
            n_err++;
            $display("FAIL reset values: got BC/busy/done %b want 100", {bus.BC, bus.busy, bus.done});
        end
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        n_vec++;
        if ({bus.BC, bus.busy, bus.done} !== 3'b100) begin
            n_err++;
            $display("FAIL idle after reset: got BC/busy/done %b want 100", {bus.BC, bus.busy, bus.done});
        end
    endtask

    task automatic test_basic();
        start_frame(8'h2A, 1024);
        run_frame("id2a_p1024", 8'h2A, 1024, 1'b0, 1'b0, 8'h00, 0);
        repeat (2) @(negedge clk);
    endtask

    task automatic test_random();
        for (int i = 0; i < 6; i++) begin
            logic [7:0]  id;
            int unsigned per;
            id  = 8'($urandom);
            per = $urandom_range(16, 300);
            start_frame(id, per);
            run_frame($sformatf("rand%0d", i), id, per, 1'b0, 1'b0, 8'h00, 0);
            repeat ($urandom_range(1, 4)) @(negedge clk);
        end
    endtask

    task automatic test_clamp();
        logic [7:0] id;
        id = 8'($urandom);
        start_frame(id, 5);
        run_frame("clamp_p5", id, 5, 1'b0, 1'b0, 8'h00, 0);
        @(negedge clk);
        id = 8'($urandom);
        start_frame(id, 0);
        run_frame("clamp_p0", id, 0, 1'b0, 1'b0, 8'h00, 0);
        @(negedge clk);
    endtask

    task automatic test_ignore_send();
        start_frame(8'hB4, 256);
        run_frame("ignore_send", 8'hB4, 256, 1'b1, 1'b0, 8'h00, 0);
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        logic [7:0] id1, id2;
        id1 = 8'($urandom);
        id2 = 8'($urandom);
        start_frame(id1, 64);
        run_frame("b2b_first", id1, 64, 1'b0, 1'b1, id2, 96);
        run_frame("b2b_second", id2, 96, 1'b0, 1'b0, 8'h00, 0);
        @(negedge clk);
    endtask

    task automatic test_reset_midframe();
        int  done_seen;
        start_frame(8'hC5, 1024);
        // Stop inside a low phase so the immediate return of BC is visible.
        repeat (3100) @(negedge clk);
        n_vec++;
        if ({bus.BC, bus.busy} !== {model_bc(8'hC5, 1024, 3100), 1'b1}) begin
            n_err++;
            $display("FAIL midframe before reset: got BC/busy %b want %b",
                     {bus.BC, bus.busy}, {model_bc(8'hC5, 1024, 3100), 1'b1});
        end
        #2 rst_n = 1'b0;
        #1;
        n_vec++;
        if ({bus.BC, bus.busy, bus.done} !== 3'b100) begin
            n_err++;
            $display("FAIL midframe reset: got BC/busy/done %b want 100", {bus.BC, bus.busy, bus.done});
        end
        done_seen = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (bus.done !== 1'b0) done_seen++;
        end
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (bus.done !== 1'b0 || bus.BC !== 1'b1) done_seen++;
        end
        n_vec++;
        if (done_seen != 0) begin
            n_err++;
            $display("FAIL midframe abandon: got %0d cycles with done/BC active want 0", done_seen);
        end
        start_frame(8'h3F, 128);
        run_frame("after_reset_3f", 8'h3F, 128, 1'b0, 1'b0, 8'h00, 0);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_random();
        test_clamp();
        test_ignore_send();
        test_back_to_back();
        test_reset_midframe();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
